// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM state encoding,
// register offsets, status bit positions and a parity helper.
package mmio_uart_pkg;

    // Serial frame FSM states
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    // Register byte offsets from BASE_ADDR
    localparam logic [31:0] DATA_OFS = 32'd0;
    localparam logic [31:0] STAT_OFS = 32'd4;

    // Status word bit positions
    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_FULL = 1;
    localparam int unsigned STAT_OVF  = 2;
    localparam int unsigned STAT_PAR  = 3;

    // Even parity: the bit that makes the total number of ones even
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with synchronous active-high reset. Pointers wrap modulo
// DEPTH (power of two); count is one bit wider so that "full" is representable.
// The caller must not push when full without a same-cycle pop, nor pop when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CountW = PtrW + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [CountW-1:0] count_q;

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            unique case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CountW'(1);
                2'b01:   count_q <= count_q - CountW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CountW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter. Stores to BASE_ADDR queue a byte; a bit-serial
// FSM sends each byte as an 8N1 frame, LSB first. Status at BASE_ADDR+4 reports
// busy/full/overflow; a store there clears the sticky overflow flag.
// Optional build macro MMIO_UART_PARITY_EN adds an even-parity bit before STOP
// and sets status bit 3.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

`ifdef MMIO_UART_PARITY_EN
    localparam logic ParBuilt = 1'b1;
`else
    localparam logic ParBuilt = 1'b0;
`endif

    uart_state_e          state_q;
    logic [CntW-1:0]      cnt_q;
    logic [2:0]           bit_q;
    logic [7:0]           shift_q;
    logic                 par_q;
    logic                 tx_q;
    logic                 ovf_q;

    logic                 data_hit;
    logic                 stat_hit;
    logic                 stat_sel;
    logic                 bit_end;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [7:0]           fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;
    logic                 unused_wdata;

    // Only the low byte of a store is transmitted
    assign unused_wdata = ^WriteData[31:8];

    assign stat_sel = (Adr == BASE_ADDR + STAT_OFS);
    assign data_hit = MemWrite && (Adr == BASE_ADDR + DATA_OFS);
    assign stat_hit = MemWrite && stat_sel;
    assign bit_end  = (cnt_q == CntW'(CLKS_PER_BIT - 1));

    // Pop either from idle or on the last STOP cycle for gapless back-to-back frames
    assign fifo_pop  = !fifo_empty &&
                       ((state_q == StIdle) || ((state_q == StStop) && bit_end));
    // A full FIFO still accepts when the same edge frees a slot
    assign fifo_push = data_hit && (!fifo_full || fifo_pop);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i (WriteData[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (unused_fifo_count)
    );

    // Sticky overflow: set by a dropped store, cleared by any status store
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (stat_hit) begin
            ovf_q <= 1'b0;
        end else if (data_hit && !fifo_push) begin
            ovf_q <= 1'b1;
        end
    end

    // Frame FSM with baud counter, bit index, shift register and registered tx
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        state_q <= StStart;
                        shift_q <= fifo_rdata;
                        par_q   <= even_parity(fifo_rdata);
                        tx_q    <= 1'b0;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        state_q <= StData;
                        tx_q    <= shift_q[0];
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            bit_q <= '0;
`ifdef MMIO_UART_PARITY_EN
                            state_q <= StParity;
                            tx_q    <= par_q;
`else
                            state_q <= StStop;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        state_q <= StStop;
                        tx_q    <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        if (!fifo_empty) begin
                            state_q <= StStart;
                            shift_q <= fifo_rdata;
                            par_q   <= even_parity(fifo_rdata);
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != StIdle) || !fifo_empty;

    // Status read decode; any other address reads zero
    always_comb begin
        ReadData = '0;
        if (stat_sel) begin
            ReadData[STAT_BUSY] = busy;
            ReadData[STAT_FULL] = fifo_full;
            ReadData[STAT_OVF]  = ovf_q;
            ReadData[STAT_PAR]  = ParBuilt;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4,
// BASE_ADDR=0x100). Works for both the default and MMIO_UART_PARITY_EN builds.
module tb_mmio_uart_tx;

    localparam int CPB = 4;
    localparam logic [31:0] DATA_A = 32'h0000_0100;
    localparam logic [31:0] STAT_A = 32'h0000_0104;
`ifdef MMIO_UART_PARITY_EN
    localparam int NBITS = 11;
    localparam logic [31:0] PAR_STAT = 32'h8;
`else
    localparam int NBITS = 10;
    localparam logic [31:0] PAR_STAT = 32'h0;
`endif
    localparam int FRAME = NBITS * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] Adr = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic        tx;
    logic        busy;

    int checks = 0;
    int failures = 0;

    mmio_uart_tx #(
        .BASE_ADDR    (32'h0000_0100),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Adr       (Adr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level for bit slot idx of a frame carrying data
    function automatic logic frame_bit(input logic [7:0] data, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return data[idx-1];
`ifdef MMIO_UART_PARITY_EN
        if (idx == 9) return ^data;
`endif
        return 1'b1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        MemWrite = 1'b0;
        Adr = STAT_A;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        Adr = STAT_A;
        for (int i = 0; i < 50; i++) begin
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || ReadData !== PAR_STAT) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d tx=%b busy=%b rd=%h required tx=1 busy=0 rd=%h",
                         i, tx, busy, ReadData, PAR_STAT);
            end
            tick();
        end
    endtask

    task automatic test_single_a5();
        logic [10:0] exp_line;
`ifdef MMIO_UART_PARITY_EN
        exp_line = 11'b1_0_10100101_0;
`else
        exp_line = 11'b0_1_10100101_0;
`endif
        MemWrite = 1'b1; Adr = DATA_A; WriteData = 32'hFFFF_FFA5;
        tick();
        MemWrite = 1'b0; Adr = STAT_A;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL a5_push_edge tx=%b busy=%b required tx=1 busy=1", tx, busy);
        end
        for (int k = 0; k < FRAME; k++) begin
            tick();
            checks++;
            if (tx !== exp_line[k / CPB]) begin
                failures++;
                $display("FAIL a5_line cycle=%0d tx=%b required %b", k, tx, exp_line[k / CPB]);
            end
            if (k == 20) begin
                checks++;
                if (ReadData !== (PAR_STAT | 32'h1)) begin
                    failures++;
                    $display("FAIL a5_status_mid rd=%h required %h", ReadData, PAR_STAT | 32'h1);
                end
            end
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL a5_busy_last_stop busy=%b required 1", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            failures++;
            $display("FAIL a5_after_frame busy=%b tx=%b required busy=0 tx=1", busy, tx);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        logic       e;
        for (int j = 0; j <= 5 * FRAME; j++) begin
            if (j < 5) begin
                MemWrite = 1'b1; Adr = DATA_A; WriteData = 32'h11 + j;
            end else begin
                MemWrite = 1'b0; Adr = STAT_A;
            end
            tick();
            if (j >= 1) begin
                b = 8'h11 + 8'((j - 1) / FRAME);
                e = frame_bit(b, ((j - 1) % FRAME) / CPB);
                checks++;
                if (tx !== e) begin
                    failures++;
                    $display("FAIL b2b_line cycle=%0d byte=%h tx=%b required %b", j, b, tx, e);
                end
            end
            if (j == 5) begin
                checks++;
                if (ReadData[2] !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_no_overflow ovf=%b required 0", ReadData[2]);
                end
            end
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_busy_last busy=%b required 1", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done busy=%b tx=%b required busy=0 tx=1", busy, tx);
        end
    endtask

    task automatic test_overflow();
        for (int j = 0; j < 6; j++) begin
            MemWrite = 1'b1; Adr = DATA_A; WriteData = 32'h21 + j;
            tick();
        end
        MemWrite = 1'b0; Adr = STAT_A;
        #1;
        checks++;
        if (ReadData !== (PAR_STAT | 32'h7)) begin
            failures++;
            $display("FAIL ovf_set rd=%h required %h", ReadData, PAR_STAT | 32'h7);
        end
        MemWrite = 1'b1; Adr = STAT_A; WriteData = 32'hFFFF_FFFF;
        tick();
        MemWrite = 1'b0;
        #1;
        checks++;
        if (ReadData !== (PAR_STAT | 32'h3)) begin
            failures++;
            $display("FAIL ovf_clear rd=%h required %h", ReadData, PAR_STAT | 32'h3);
        end
        Adr = DATA_A;
        #1;
        checks++;
        if (ReadData !== 32'h0) begin
            failures++;
            $display("FAIL read_data_reg rd=%h required 0", ReadData);
        end
        do_reset();
    endtask

    task automatic test_reset_midframe();
        for (int j = 0; j < 3; j++) begin
            MemWrite = 1'b1; Adr = DATA_A; WriteData = 32'h31 + j;
            tick();
        end
        MemWrite = 1'b0; Adr = STAT_A;
        for (int j = 0; j < 11; j++) tick();
        // 13 cycles into the frame of 0x31: data bit 2 is on the line
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midframe_line tx=%b busy=%b required tx=0 busy=1", tx, busy);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || ReadData !== PAR_STAT) begin
            failures++;
            $display("FAIL midframe_reset tx=%b busy=%b rd=%h required tx=1 busy=0 rd=%h",
                     tx, busy, ReadData, PAR_STAT);
        end
        reset = 1'b0;
        for (int j = 0; j < 60; j++) begin
            tick();
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL midframe_quiet cycle=%0d tx=%b busy=%b required tx=1 busy=0",
                         j, tx, busy);
            end
        end
    endtask

    task automatic test_addr_decode();
        logic [31:0] addrs [4];
        addrs[0] = 32'h0000_0101;
        addrs[1] = 32'h0000_0108;
        addrs[2] = 32'h0000_0000;
        addrs[3] = 32'h0100_0100;
        for (int j = 0; j < 4; j++) begin
            MemWrite = 1'b1; Adr = addrs[j]; WriteData = 32'h55;
            tick();
            MemWrite = 1'b0;
            #1;
            checks++;
            if (busy !== 1'b0 || ReadData !== 32'h0) begin
                failures++;
                $display("FAIL addr_ignored adr=%h busy=%b rd=%h required busy=0 rd=0",
                         addrs[j], busy, ReadData);
            end
        end
        Adr = STAT_A;
        for (int j = 0; j < 2 * CPB; j++) begin
            tick();
            checks++;
            if (tx !== 1'b1) begin
                failures++;
                $display("FAIL addr_line tx=%b required 1", tx);
            end
        end
    endtask

`ifdef MMIO_UART_PARITY_EN
    task automatic test_parity();
        logic e;
        MemWrite = 1'b1; Adr = DATA_A; WriteData = 32'h07;
        tick();
        MemWrite = 1'b0; Adr = STAT_A;
        for (int k = 0; k < FRAME; k++) begin
            tick();
            e = frame_bit(8'h07, k / CPB);
            checks++;
            if (tx !== e) begin
                failures++;
                $display("FAIL parity_line cycle=%0d tx=%b required %b", k, tx, e);
            end
        end
        checks++;
        if (ReadData !== 32'h9) begin
            failures++;
            $display("FAIL parity_status rd=%h required 9", ReadData);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || ReadData !== 32'h8) begin
            failures++;
            $display("FAIL parity_done busy=%b rd=%h required busy=0 rd=8", busy, ReadData);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_addr_decode();
`ifdef MMIO_UART_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmit peripheral on the processor's store bus: consumes MemWrite/Adr/WriteData alongside the shared memory.
- Stores to the data register push a byte into a small FIFO.
- A bit-serial FSM drains the FIFO onto a 1-wire 8N1 line.
- A status register is readable through ReadData so firmware can poll full/busy/overflow.

Parameters:
- BASE_ADDR, 32'h0000_0100, word address of the data register; status register at BASE_ADDR+4.
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 4, byte entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- MemWrite  in  1  store strobe from processor.
- Adr  in  32  byte address from processor.
- WriteData  in  32  store data; only bits [7:0] are used.
- ReadData  out  32  status word, combinational from Adr.
- tx  out  1  serial line, idle high.
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

Behaviour:
- Reset values: tx=1, busy=0, FIFO empty, overflow=0, FSM=IDLE, baud counter=0, bit index=0.
- Reset asserted mid-frame aborts the frame: tx=1 at the next edge and FIFO contents are discarded.
- Push condition: MemWrite && Adr==BASE_ADDR.
  - WriteData[7:0] is enqueued on that edge if the FIFO is not full, or if it is full and a pop happens on the same edge.
  - Otherwise the byte is dropped and sticky overflow is set.
- Status write: MemWrite && Adr==BASE_ADDR+4 clears overflow; the write data is ignored.
- Status read: ReadData = {29'b0, overflow, full, busy} when Adr==BASE_ADDR+4, else 32'b0.
  - Combinational, no latency.
  - full and empty are derived from the FIFO count. full means count==FIFO_DEPTH.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START. Pop and start happen on the same edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the final cycle, if the FIFO is non-empty, pop and go to START (back-to-back, no idle gap); else go to IDLE.
- Latency: a push into an empty FIFO on edge N gives pop/START on edge N+1, so tx falls after edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps at a bit boundary.
  - Width is $clog2(CLKS_PER_BIT).
  - Reset to 0 on every state change.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is one bit wider.
- A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Addresses other than the two registers are ignored; there is no partial-address aliasing.

Optional Feature:
- Macro: MMIO_UART_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - PARITY drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT.
  - Status bit 3 reads 1 to flag that parity is built in.
- When undefined: plain 8N1 frame and status bit 3 reads 0.

Decomposition:
- Package mmio_uart_pkg holds:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP).
  - Register offset constants: DATA_OFS=0, STAT_OFS=4.
  - Status bit positions: BUSY=0, FULL=1, OVF=2, PAR=3.
- Sub-module sync_fifo:
  - Parameterised width/depth; push/pop/full/empty/count.
  - Same clk/reset convention.
  - Top holds the FSM, baud counter and address decode.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=0x100):
- Reset, no stores -> tx=1, busy=0, read of 0x104 returns 0 for 50 cycles.
- Store 0x000000A5 to 0x100 on edge N -> tx falls after N+1; line shows 0,1,0,1,0,0,1,0,1,1, each 4 cycles; busy drops after the 40-cycle frame.
- Five stores 0x11..0x15 in consecutive cycles while idle -> four accepted, one popped at once, the fifth accepted; five back-to-back frames with no idle gap between frames; overflow=0.
- Six consecutive stores while idle -> the sixth is dropped, 0x104 reads overflow bit = 1; a store to 0x104 clears it to 0.
- Reset asserted 13 cycles into a frame with 2 bytes queued -> tx=1 next cycle, busy=0, no further frames.
- With MMIO_UART_PARITY_EN, store 0x07 -> parity bit 1 after data, frame is 44 cycles, status bit 3 = 1.
